// File: rtl/dmem_responder.sv
// dmem_responder: word RAM load/store responder with wait states, busy flag and saturating transaction count
// Ports: clk, reset (async, active-high)
//        req_valid/req_ready/req_we/req_addr/req_wdata/req_be : request channel from the MEM stage
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err                : response channel back to the core
//        busy      : high while a transaction is in flight (WAIT or RESP)
//        txn_count : completed transactions, saturating at all-ones
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] wcnt, wcnt_nx;
  logic cap_we;
  logic [29:0] cap_idx;
  logic [31:0] cap_wdata;
  logic [3:0] cap_be;
  logic [31:0] mem [DEPTH_WORDS];
  logic in_range, access, accept, consume, unused_addr;
  assign unused_addr = ^req_addr[1:0];
  assign in_range = {2'b00, cap_idx} < 32'(DEPTH_WORDS);
  assign accept = state == IDLE && req_valid;
  // The RAM access fires on the edge that leaves WAIT, so stores commit before their response appears.
  assign access = state == WAIT && wcnt == 4'd0;
  assign consume = state == RESP && rsp_ready;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    wcnt_nx = wcnt;
    if (accept) begin
      state_nx = WAIT;
      wcnt_nx = 4'(LATENCY - 1);
    end else if (state == WAIT) begin
      state_nx = wcnt == 4'd0 ? RESP : WAIT;
      wcnt_nx = wcnt == 4'd0 ? wcnt : wcnt - 4'd1;
    end else if (consume) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= 4'd0;
      cap_we <= 1'b0;
      cap_idx <= 30'd0;
      cap_wdata <= 32'd0;
      cap_be <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
      txn_count <= '0;
    end else begin
      state <= state_nx;
      wcnt <= wcnt_nx;
      if (accept) begin
        cap_we <= req_we;
        cap_idx <= req_addr[31:2];
        cap_wdata <= req_wdata;
        cap_be <= req_be;
      end
      if (access) begin
        rsp_rdata <= in_range && !cap_we ? mem[cap_idx[AW-1:0]] : 32'd0;
        rsp_err <= !in_range;
      end else if (consume) begin
        rsp_rdata <= 32'd0;
        rsp_err <= 1'b0;
        txn_count <= &txn_count ? txn_count : txn_count + CNT_W'(1);
      end
    end
  end
  // RAM has no reset; a store caught by reset never reaches the access edge, so it is dropped.
  always_ff @(posedge clk) begin
    if (access && in_range && cap_we)
      for (int i = 0; i < 4; i++)
        if (cap_be[i]) mem[cap_idx[AW-1:0]][8*i +: 8] <= cap_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder against a word-array reference model
module tb_dmem_responder;
  localparam int LAT = 2;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, reset = 1, req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_be = 0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [CW-1:0] txn_count;
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .txn_count(txn_count)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, n = 0, acc = 0;
  bit active = 0, consume_pending = 0;
  logic [32:0] exp_q[$];
  int acc_q[$];
  logic [32:0] cur = 0;
  logic [31:0] model [1024];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask
  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask
  function automatic int sat(int v);
    return v > SAT ? SAT : v;
  endfunction
  task automatic issue(bit we, logic [31:0] addr, logic [31:0] wd, logic [3:0] be);
    int k = 0;
    int idx = int'(addr[31:2]);
    logic [32:0] e;
    while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (!req_ready) timeout("req_ready");
    if (idx >= 1024) e = {1'b1, 32'h0};
    else if (we) begin
      for (int i = 0; i < 4; i++) if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
      e = 33'h0;
    end else e = {1'b0, model[idx]};
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    acc_q.push_back(cyc);
    req_valid = 0;
  endtask
  task automatic wait_rsp(int hold);
    int k = 0;
    while (!rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
    if (!rsp_valid) begin timeout("rsp_valid"); return; end
    repeat (hold) begin
      req_valid = 1; req_we = 1; req_addr = 32'h0C; req_wdata = $urandom; req_be = 4'hF;
      @(posedge clk); #1;
    end
    req_valid = 0; rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask
  always @(negedge clk) if (!reset) begin
    if (consume_pending) begin
      consume_pending = 0;
      n++;
      chk("idle_after_consume", {rsp_valid, req_ready, busy, rsp_err, rsp_rdata}, {4'b0100, 32'h0});
    end
    chk("txn_count", txn_count, sat(n));
    if (rsp_valid) begin
      if (!active) begin
        active = 1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got response with nothing outstanding");
          cur = {rsp_err, rsp_rdata}; acc = cyc - LAT;
        end else begin
          cur = exp_q.pop_front();
          acc = acc_q.pop_front();
          chk("latency", cyc - acc, LAT);
        end
      end
      chk("rsp_data", {rsp_err, rsp_rdata}, cur);
      chk("resp_flags", {busy, req_ready}, 2'b10);
      if (rsp_ready) begin consume_pending = 1; active = 0; end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
  initial begin
    logic we;
    logic [31:0] a;
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", {req_ready, rsp_valid, busy, rsp_err, rsp_rdata, txn_count}, {4'b1000, 32'h0, {CW{1'b0}}});
    reset = 0;
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF); wait_rsp(0);
    chk("txn_after_first", txn_count, 1);
    issue(0, 32'h10, 0, 4'h0); wait_rsp(1);
    issue(1, 32'h10, 32'h000000AA, 4'b0001); wait_rsp(0);
    issue(0, 32'h10, 0, 4'h0); wait_rsp(0);
    issue(0, 32'h1000, 0, 4'h0); wait_rsp(2);
    issue(0, 32'h10, 0, 4'h0); wait_rsp(5);
    issue(1, 32'h10, 32'hFFFFFFFF, 4'h0); wait_rsp(0);
    issue(0, 32'h13, 0, 4'h0); wait_rsp(0);
    for (int i = 0; i < 16; i++) if (i != 4) begin
      issue(1, 32'(i * 4), i == 8 ? 32'h11111111 : $urandom, 4'hF);
      wait_rsp(0);
    end
    req_we = 1; req_addr = 32'h20; req_wdata = 32'h22222222; req_be = 4'hF; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    chk("busy_in_wait", {busy, req_ready, rsp_valid}, 3'b100);
    #2;
    reset = 1; n = 0; active = 0; consume_pending = 0;
    #1;
    chk("async_reset_outputs", {req_ready, rsp_valid, busy, rsp_err, rsp_rdata, txn_count}, {4'b1000, 32'h0, {CW{1'b0}}});
    @(posedge clk); #1; @(posedge clk); #1;
    reset = 0;
    issue(0, 32'h20, 0, 4'h0); wait_rsp(0);
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 7) == 0 ? (32'h1000 | ($urandom & 32'h0FFF_FFFF))
                                    : 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      issue(we, a, $urandom, 4'($urandom));
      wait_rsp($urandom_range(0, 3));
    end
    repeat (3) @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("txn_saturated", txn_count, SAT);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
